// File: rtl/arb2_stream.sv
// rtl/arb2_stream.sv - two-input round-robin packet arbiter with single-entry output buffer
module arb2_stream #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_last,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_last,
  output logic             b_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             sel,
  output logic             err_trunc
);

  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BEATS);

  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;

  state_t           r_state;
  logic             r_prio;
  logic [CW-1:0]    r_beat_cnt;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_last;
  logic             r_sel;
  logic             r_err_trunc;

  logic             w_load_en;
  logic             w_a_ready;
  logic             w_b_ready;
  logic             w_acc;
  logic [WIDTH-1:0] w_in_data;
  logic             w_in_last;
  logic [CW-1:0]    w_cnt_inc;
  logic             w_wd_hit;
  logic             w_release;

  // The buffer can take a new beat when empty or when its current beat drains this edge.
  assign w_load_en = !r_out_valid | out_ready;
  assign w_a_ready = rst_n & (r_state == GRANT_A) & w_load_en;
  assign w_b_ready = rst_n & (r_state == GRANT_B) & w_load_en;
  assign w_acc     = (a_valid & w_a_ready) | (b_valid & w_b_ready);
  assign w_in_data = (r_state == GRANT_B) ? b_data : a_data;
  assign w_in_last = (r_state == GRANT_B) ? b_last : a_last;
  assign w_cnt_inc = r_beat_cnt + CW'(1);
  assign w_wd_hit  = (w_cnt_inc == MAX_CNT);
  assign w_release = w_acc & (w_in_last | w_wd_hit);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_prio      <= 1'b0;
      r_beat_cnt  <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_sel       <= 1'b0;
      r_err_trunc <= 1'b0;
    end else begin
      r_err_trunc <= w_acc & w_wd_hit & !w_in_last;

      if (w_acc) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_in_data;
        r_out_last  <= w_in_last | w_wd_hit;
      end else if (r_out_valid & out_ready) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (a_valid & b_valid) begin
            r_state <= r_prio ? GRANT_B : GRANT_A;
            r_sel   <= r_prio;
          end else if (a_valid) begin
            r_state <= GRANT_A;
            r_sel   <= 1'b0;
          end else if (b_valid) begin
            r_state <= GRANT_B;
            r_sel   <= 1'b1;
          end
        end
        GRANT_A, GRANT_B: begin
          if (w_release) begin
            // Hand priority to the other stream on every release, forced or normal.
            r_state    <= IDLE;
            r_sel      <= 1'b0;
            r_prio     <= (r_state == GRANT_A);
            r_beat_cnt <= '0;
          end else if (w_acc) begin
            r_beat_cnt <= w_cnt_inc;
          end
        end
        default: begin
          r_state <= IDLE;
          r_sel   <= 1'b0;
        end
      endcase
    end
  end

  assign a_ready   = w_a_ready;
  assign b_ready   = w_b_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign sel       = r_sel;
  assign err_trunc = r_err_trunc;

endmodule
